// File: rtl/ysyx_23060059_rd_arbiter.sv
// Two-master AXI read arbiter: IFU (0) and LSU (1) share one xbar read port, one
// transaction in flight, round-robin on ties, single response beat routed to its owner.

// Per-master response steering: the owner sees the xbar beat, everyone else sees zeros.
module ysyx_23060059_rd_arb_resp #(
  parameter int DATA_W = 64
) (
  input  logic              sel_i,
  input  logic              tag_err_i,
  input  logic              s_rvalid_i,
  input  logic [DATA_W-1:0] s_rdata_i,
  input  logic [1:0]        s_rresp_i,
  input  logic              rready_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rresp_o,
  output logic              rready_o
);
  assign rvalid_o = sel_i & s_rvalid_i;
  assign rdata_o  = sel_i ? s_rdata_i : '0;
  assign rresp_o  = !sel_i ? 2'b00 : (tag_err_i ? 2'b10 : s_rresp_i);
  assign rready_o = sel_i & rready_i;
endmodule

module ysyx_23060059_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [2:0]        m0_arsize,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [2:0]        m1_arsize,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [2:0]        s_arsize,
  output logic [3:0]        s_arid,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic [3:0]        s_rid,
  input  logic              s_rlast
);
  localparam int NUM_M = 2;

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
  } ar_req_t;

  state_e  state_q;
  logic    owner_q, last_q;
  ar_req_t ar_q;
  logic [3:0] arid_q;

  ar_req_t [NUM_M-1:0]             req;
  logic    [NUM_M-1:0]             arvalid, arready, rready, rvalid, rrdy;
  logic    [NUM_M-1:0][DATA_W-1:0] rdata;
  logic    [NUM_M-1:0][1:0]        rresp;
  logic grant, ar_hs, in_data, tag_err, r_hs;

  assign req[0]  = '{addr: m0_araddr, size: m0_arsize};
  assign req[1]  = '{addr: m1_araddr, size: m1_arsize};
  assign arvalid = {m1_arvalid, m0_arvalid};
  assign rready  = {m1_rready, m0_rready};

  // Ties go to whichever master was not served last.
  always_comb begin
    grant = 1'b0;
    case (arvalid)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_q;
      default: grant = 1'b0;
    endcase
  end

  assign arready[0] = !reset && (state_q == IDLE) && arvalid[0] && !grant;
  assign arready[1] = !reset && (state_q == IDLE) && arvalid[1] && grant;
  assign ar_hs      = |arready;
  assign in_data    = (state_q == DATA);
  assign tag_err    = (s_rid[0] != owner_q);

  generate
    for (genvar g = 0; g < NUM_M; g++) begin : g_resp
      ysyx_23060059_rd_arb_resp #(.DATA_W(DATA_W)) u_resp (
        .sel_i      (in_data && (owner_q == 1'(g))),
        .tag_err_i  (tag_err),
        .s_rvalid_i (s_rvalid),
        .s_rdata_i  (s_rdata),
        .s_rresp_i  (s_rresp),
        .rready_i   (rready[g]),
        .rvalid_o   (rvalid[g]),
        .rdata_o    (rdata[g]),
        .rresp_o    (rresp[g]),
        .rready_o   (rrdy[g])
      );
    end
  endgenerate

  assign s_rready = |rrdy;
  assign r_hs     = in_data && s_rvalid && s_rready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      ar_q    <= '0;
      arid_q  <= 4'd0;
    end else begin
      case (state_q)
        IDLE: if (ar_hs) begin
          state_q <= ADDR;
          owner_q <= grant;
          arid_q  <= {3'b000, grant};
          ar_q    <= req[grant];
        end
        ADDR: if (s_arready) state_q <= DATA;
        DATA: if (r_hs) begin
          last_q  <= owner_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_arvalid  = (state_q == ADDR);
  assign s_araddr   = ar_q.addr;
  assign s_arsize   = ar_q.size;
  assign s_arid     = arid_q;
  assign m0_arready = arready[0];
  assign m1_arready = arready[1];
  assign m0_rvalid  = rvalid[0];
  assign m1_rvalid  = rvalid[1];
  assign m0_rdata   = rdata[0];
  assign m1_rdata   = rdata[1];
  assign m0_rresp   = rresp[0];
  assign m1_rresp   = rresp[1];

  // Single-beat transfers only; upper tag bits carry nothing this block uses.
  logic unused_in;
  assign unused_in = ^{s_rlast, s_rid[3:1]};
endmodule
